// File: rtl/sync_fifo.sv
// Single-clock FIFO with a STANDARD (registered read) or first-word-fall-through
// read port. Any depth >= 2; all status flags are registered from the next fill level.
module sync_fifo #(
  parameter int    FIFO_LEN       = 512,
  parameter int    DATA_WIDTH     = 8,
  parameter int    UPPER_TRESHOLD = 510,
  parameter int    LOWER_TRESHOLD = 10,
  parameter string READ_MODE      = "STANDARD",
  localparam int   LW             = $clog2(FIFO_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clken,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_upper,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_dv,
  output logic                  rd_empty,
  output logic                  rd_lower,
  output logic                  underflow,
  output logic [LW-1:0]         level
);

  localparam int PW   = $clog2(FIFO_LEN);
  localparam bit FWFT = (READ_MODE == "FWFT");

  if (READ_MODE != "STANDARD" && READ_MODE != "FWFT") begin : g_bad_mode
    $error("sync_fifo: READ_MODE must be \"STANDARD\" or \"FWFT\"");
  end
  if (FIFO_LEN < 2) begin : g_bad_len
    $error("sync_fifo: FIFO_LEN must be >= 2");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_LEN];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc, ram_rd, dv_nxt;
  logic [LW-1:0]         level_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_LEN - 1)) ? '0 : p + PW'(1);
  endfunction

  // In FWFT the presented word lives in the rd_data register and still counts
  // in level, so the RAM holds level - rd_dv words.
  always_comb begin
    wr_acc = wr_en && !wr_full;
    if (FWFT) begin
      rd_acc = rd_en && rd_dv;
      ram_rd = (level > LW'(rd_dv)) && (!rd_dv || rd_en);
      dv_nxt = ram_rd || (rd_dv && !rd_en);
    end else begin
      rd_acc = rd_en && !rd_empty;
      ram_rd = rd_acc;
      dv_nxt = rd_acc;
    end
    level_nxt = level;
    if (wr_acc && !rd_acc)      level_nxt = level + LW'(1);
    else if (rd_acc && !wr_acc) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_dv     <= 1'b0;
      rd_empty  <= 1'b1;
      wr_full   <= 1'b0;
      wr_upper  <= (UPPER_TRESHOLD <= 0);
      rd_lower  <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clken) begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_rd) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_data <= mem[rd_ptr];
      end
      rd_dv     <= dv_nxt;
      level     <= level_nxt;
      rd_empty  <= FWFT ? !dv_nxt : (level_nxt == '0);
      wr_full   <= (int'(level_nxt) == FIFO_LEN);
      wr_upper  <= (int'(level_nxt) >= UPPER_TRESHOLD);
      rd_lower  <= (int'(level_nxt) <= LOWER_TRESHOLD);
      overflow  <= wr_en && wr_full;
      underflow <= rd_en && !rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && clken && wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a STANDARD depth-5 instance and a FWFT depth-512 instance,
// each checked every cycle against a queue model, plus directed literal checks.
module tb_sync_fifo;

  localparam int LEN0 = 5,   UP0 = 4,   LO0 = 1;
  localparam int LEN1 = 512, UP1 = 510, LO1 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clken [2], rst_n [2], wr_en [2], rd_en [2];
  logic [7:0] wr_data [2], rd_data [2];
  logic       wr_full [2], wr_upper [2], overflow [2];
  logic       rd_dv [2], rd_empty [2], rd_lower [2], underflow [2];
  logic [2:0] level0;
  logic [9:0] level1;

  int total = 0, bad = 0;

  sync_fifo #(.FIFO_LEN(LEN0), .DATA_WIDTH(8), .UPPER_TRESHOLD(UP0),
              .LOWER_TRESHOLD(LO0), .READ_MODE("STANDARD")) u_std (
    .clk(clk), .rst_n(rst_n[0]), .clken(clken[0]),
    .wr_en(wr_en[0]), .wr_data(wr_data[0]), .wr_full(wr_full[0]),
    .wr_upper(wr_upper[0]), .overflow(overflow[0]), .rd_en(rd_en[0]),
    .rd_data(rd_data[0]), .rd_dv(rd_dv[0]), .rd_empty(rd_empty[0]),
    .rd_lower(rd_lower[0]), .underflow(underflow[0]), .level(level0));

  sync_fifo #(.FIFO_LEN(LEN1), .DATA_WIDTH(8), .UPPER_TRESHOLD(UP1),
              .LOWER_TRESHOLD(LO1), .READ_MODE("FWFT")) u_fwft (
    .clk(clk), .rst_n(rst_n[1]), .clken(clken[1]),
    .wr_en(wr_en[1]), .wr_data(wr_data[1]), .wr_full(wr_full[1]),
    .wr_upper(wr_upper[1]), .overflow(overflow[1]), .rd_en(rd_en[1]),
    .rd_data(rd_data[1]), .rd_dv(rd_dv[1]), .rd_empty(rd_empty[1]),
    .rd_lower(rd_lower[1]), .underflow(underflow[1]), .level(level1));

  // Model: circular list of words with the edge number each was written at.
  // FWFT head is visible after edge E iff it was written at an edge before E.
  logic [7:0] md [2][512];
  int         mwe [2][512];
  int         mhead [2], mcnt [2], medge [2];
  bit         e_dv [2], e_ovf [2], e_unf [2], ready [2];
  logic [7:0] e_data [2];

  always @(posedge clk) begin
    int len, slot;
    bit fw, full, wacc, racc;
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? LEN0 : LEN1;
      fw  = (i == 1);
      if (!rst_n[i]) begin
        ready[i] = 1; mhead[i] = 0; mcnt[i] = 0; medge[i] = 0;
        e_dv[i] = 0; e_data[i] = 8'h00; e_ovf[i] = 0; e_unf[i] = 0;
      end else if (clken[i]) begin
        full     = (mcnt[i] == len);
        wacc     = wr_en[i] && !full;
        racc     = rd_en[i] && (fw ? e_dv[i] : (mcnt[i] != 0));
        e_ovf[i] = wr_en[i] && full;
        e_unf[i] = rd_en[i] && !racc;
        if (racc) begin
          if (!fw) e_data[i] = md[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % len;
          mcnt[i]--;
        end
        if (wacc) begin
          slot = (mhead[i] + mcnt[i]) % len;
          md[i][slot]  = wr_data[i];
          mwe[i][slot] = medge[i];
          mcnt[i]++;
        end
        if (fw) begin
          e_dv[i] = (mcnt[i] != 0) && (mwe[i][mhead[i]] < medge[i]);
          if (e_dv[i]) e_data[i] = md[i][mhead[i]];
        end else begin
          e_dv[i] = racc;
        end
        medge[i]++;
      end
    end
  end

  always @(negedge clk) begin
    int len, up, lo;
    logic [31:0] lv;
    logic [6:0]  act_f, exp_f;
    for (int i = 0; i < 2; i++) begin
      if (ready[i]) begin
        len = (i == 0) ? LEN0 : LEN1;
        up  = (i == 0) ? UP0 : UP1;
        lo  = (i == 0) ? LO0 : LO1;
        lv  = (i == 0) ? 32'(level0) : 32'(level1);
        act_f = {overflow[i], underflow[i], wr_full[i], wr_upper[i],
                 rd_lower[i], rd_empty[i], rd_dv[i]};
        exp_f = {e_ovf[i], e_unf[i], mcnt[i] == len, mcnt[i] >= up, mcnt[i] <= lo,
                 (i == 1) ? !e_dv[i] : (mcnt[i] == 0), e_dv[i]};
        total++;
        if (act_f !== exp_f || rd_data[i] !== e_data[i] || lv !== 32'(mcnt[i])) begin
          bad++;
          $display("FAIL model_cmp[%0d] t=%0t: ovf/unf/full/up/low/emp/dv=%b data=%h level=%0d, expected %b data=%h level=%0d",
                   i, $time, act_f, rd_data[i], lv, exp_f, e_data[i], mcnt[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int i, input bit ce, input bit rs, input bit we,
                     input logic [7:0] wd, input bit re);
    clken[i] = ce; rst_n[i] = rs; wr_en[i] = we; wr_data[i] = wd; rd_en[i] = re;
    @(posedge clk); #1;
    wr_en[i] = 1'b0; rd_en[i] = 1'b0; clken[i] = 1'b1; rst_n[i] = 1'b1;
  endtask

  task automatic rand_run(input int i, input int n, input int pw, input int pr, input int rr);
    bit ce, rs, we, re;
    for (int k = 0; k < n; k++) begin
      ce = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 999) >= rr);
      we = ($urandom_range(0, 99) < pw);
      re = ($urandom_range(0, 99) < pr);
      cyc(i, ce, rs, we, 8'($urandom), re);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clken[i] = 1'b1; rst_n[i] = 1'b0; wr_en[i] = 1'b0; rd_en[i] = 1'b0; wr_data[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level0", level0, 0);
    chk("rst_empty0", rd_empty[0], 1);
    chk("rst_lower0", rd_lower[0], 1);
    chk("rst_upper1", wr_upper[1], 0);
    chk("rst_dv1", rd_dv[1], 0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // STANDARD basic round trip
    cyc(0, 1, 1, 1, 8'h11, 0); cyc(0, 1, 1, 1, 8'h22, 0); cyc(0, 1, 1, 1, 8'h33, 0);
    chk("std_level3", level0, 3);
    chk("std_not_empty", rd_empty[0], 0);
    cyc(0, 1, 1, 0, 8'h00, 1); chk("std_rd11", rd_data[0], 8'h11); chk("std_dv", rd_dv[0], 1);
    cyc(0, 1, 1, 0, 8'h00, 1); chk("std_rd22", rd_data[0], 8'h22);
    cyc(0, 1, 1, 0, 8'h00, 1); chk("std_rd33", rd_data[0], 8'h33);
    chk("std_level0", level0, 0); chk("std_empty", rd_empty[0], 1);
    cyc(0, 1, 1, 0, 8'h00, 0); chk("std_dv_low", rd_dv[0], 0); chk("std_hold", rd_data[0], 8'h33);

    // wrap and full
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 1, 8'(8'h40 + k), 0);
    for (int k = 0; k < 7; k++) begin
      cyc(0, 1, 1, 1, 8'(8'h50 + k), 1);
      chk("wrap_rd", rd_data[0], (k < 3) ? 32'(8'h40 + k) : 32'(8'h50 + k - 3));
    end
    cyc(0, 1, 1, 1, 8'h60, 0); cyc(0, 1, 1, 1, 8'h61, 0);
    chk("full_level", level0, 5); chk("full_flag", wr_full[0], 1);
    cyc(0, 1, 1, 1, 8'h62, 0);
    chk("ovf_pulse", overflow[0], 1); chk("ovf_level", level0, 5);
    cyc(0, 1, 1, 0, 8'h00, 0); chk("ovf_clear", overflow[0], 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 8'h00, 1);
    chk("drain_last", rd_data[0], 8'h61); chk("drain_empty", rd_empty[0], 1);

    // empty corner: simultaneous write+read
    cyc(0, 1, 1, 1, 8'h77, 1);
    chk("corner_unf", underflow[0], 1); chk("corner_level", level0, 1);
    cyc(0, 1, 1, 0, 8'h00, 1);
    chk("corner_rd", rd_data[0], 8'h77); chk("corner_unf_clr", underflow[0], 0);

    // FWFT latency and streaming
    cyc(1, 1, 1, 1, 8'hA5, 0); chk("fwft_not_yet", rd_dv[1], 0); chk("fwft_lvl1", level1, 1);
    cyc(1, 1, 1, 0, 8'h00, 0); chk("fwft_dv", rd_dv[1], 1); chk("fwft_a5", rd_data[1], 8'hA5);
    cyc(1, 1, 1, 0, 8'h00, 1); chk("fwft_consumed", rd_dv[1], 0); chk("fwft_lvl0", level1, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 1, 1, 8'(8'hB0 + k), 0);
    cyc(1, 1, 1, 0, 8'h00, 0); chk("fwft_b0", rd_data[1], 8'hB0); chk("fwft_lvl4", level1, 4);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 1, 0, 8'h00, 1);
      if (k < 3) chk("fwft_stream", rd_data[1], 32'(8'hB1 + k));
      else       chk("fwft_stream_end", rd_dv[1], 0);
    end

    // thresholds
    for (int k = 0; k < 10; k++) cyc(1, 1, 1, 1, 8'(k), 0);
    chk("thr_lower10", rd_lower[1], 1);
    cyc(1, 1, 1, 1, 8'h0a, 0); chk("thr_lower11", rd_lower[1], 0);
    for (int k = 11; k < 510; k++) cyc(1, 1, 1, 1, 8'(k), 0);
    chk("thr_lvl510", level1, 510); chk("thr_upper510", wr_upper[1], 1);
    cyc(1, 1, 1, 0, 8'h00, 1); chk("thr_upper509", wr_upper[1], 0);
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 1, 8'hEE, 0);
    chk("fwft_full", wr_full[1], 1);
    cyc(1, 1, 1, 1, 8'hEF, 0); chk("fwft_ovf", overflow[1], 1); chk("fwft_full_lvl", level1, 512);

    // reset mid-operation with clken low
    cyc(1, 1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 7; k++) cyc(1, 1, 1, 1, 8'(8'hC0 + k), 0);
    cyc(1, 1, 1, 0, 8'h00, 0);
    chk("mid_lvl7", level1, 7); chk("mid_dv", rd_dv[1], 1);
    cyc(1, 0, 0, 0, 8'h00, 0);
    chk("mid_rst_lvl", level1, 0); chk("mid_rst_dv", rd_dv[1], 0);
    chk("mid_rst_data", rd_data[1], 0); chk("mid_rst_empty", rd_empty[1], 1);
    chk("mid_rst_lower", rd_lower[1], 1); chk("mid_rst_full", wr_full[1], 0);
    cyc(1, 1, 1, 1, 8'hC3, 0); cyc(1, 1, 1, 0, 8'h00, 0);
    chk("mid_rt_data", rd_data[1], 8'hC3);
    cyc(1, 1, 1, 0, 8'h00, 1); chk("mid_rt_lvl", level1, 0);

    // randomized phases (each checked by the model every cycle)
    rand_run(0, 400, 50, 50, 3);
    rand_run(0, 300, 85, 25, 0);
    rand_run(0, 300, 25, 85, 2);
    rand_run(1, 300, 50, 50, 3);
    rand_run(1, 1300, 90, 20, 0);
    rand_run(1, 1300, 20, 90, 0);
    rand_run(1, 300, 60, 60, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
